// File: rtl/tau_mac_seq.sv
// tau_mac_seq: walks set bits of a MSB-first, accumulating (b << k) per bit into a dot product
module tau_mac_seq #(
  parameter int BITWIDTH = 8,
  parameter int VEC_LEN  = 4,
  parameter int ACC_BITS = 2*BITWIDTH + $clog2(VEC_LEN)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_a,
  input  logic [BITWIDTH-1:0] in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] out_acc,
  output logic                busy
);
  localparam int KW = BITWIDTH > 1 ? $clog2(BITWIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [BITWIDTH-1:0] a_q, b_q;
  logic last_q;
  logic [ACC_BITS-1:0] acc;
  logic [KW-1:0] k;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // next-state: one handshake per state, scan runs until a_q is exhausted
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? SCAN : IDLE;
      SCAN:    state_nx = |a_q ? SCAN : (last_q ? DONE : IDLE);
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // index of the highest set bit of the remaining multiplier
  always_comb begin
    k = '0;
    for (int i = 0; i < BITWIDTH; i++) if (a_q[i]) k = KW'(i);
  end
  // operand capture, per-bit accumulate, clear on result handoff
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      last_q <= 1'b0;
      acc <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
        last_q <= in_last;
      end
      if (state == SCAN && |a_q) begin
        acc <= acc + (ACC_BITS'(b_q) << k);
        a_q[k] <= 1'b0;
      end
      if (state == DONE && out_ready) acc <= '0;
    end
  // outputs decoded from state
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    out_acc = acc;
  end
endmodule

// File: tb/tb_tau_mac_seq.sv
// tb_tau_mac_seq: table vectors, corner sequences and random dot products against an arithmetic model
module tb_tau_mac_seq;
  logic clk = 0, reset_n = 0;
  logic in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 0, busy;
  logic [7:0] in_a = 0, in_b = 0;
  logic [17:0] out_acc;
  int n_vec = 0, n_err = 0;
  logic [17:0] model;
  typedef struct {logic [7:0] a; logic [7:0] b; logic last; logic [17:0] exp;} vec_t;
  vec_t tbl[8];

  tau_mac_seq dut (.clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n) check("ready_valid_exclusive", {31'd0, in_ready & out_valid}, 0);

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l, output int n);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 1);
    in_a = a; in_b = b; in_last = l; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_a = 8'($urandom); in_b = 8'($urandom); in_last = 1'($urandom);
    n = 0;
    while (!(out_valid || in_ready) && n < 300) begin @(posedge clk); #1; n++; end
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic l);
    int n;
    send(a, b, l, n);
    check("scan_cycles", n, $countones(a) + 1);
    model = model + 18'(a * b);
    check("out_valid_after_pair", {31'd0, out_valid}, {31'd0, l});
    check("in_ready_after_pair", {31'd0, in_ready}, {31'd0, !l});
  endtask

  task automatic drain(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 1);
      check("hold_acc", out_acc, model);
      check("hold_in_ready", {31'd0, in_ready}, 0);
    end
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    check("drain_valid", {31'd0, out_valid}, 0);
    check("drain_in_ready", {31'd0, in_ready}, 1);
    check("drain_acc_cleared", out_acc, 0);
    model = 0;
  endtask

  initial begin
    model = 0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_busy", {31'd0, busy}, 0);
    @(negedge clk); reset_n = 1;

    tbl[0] = '{8'h05, 8'h03, 1'b1, 18'd15};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 18'd0};
    tbl[2] = '{8'h01, 8'h02, 1'b1, 18'd65027};
    tbl[3] = '{8'h00, 8'hAB, 1'b1, 18'd0};
    tbl[4] = '{8'hFF, 8'hFF, 1'b0, 18'd0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b0, 18'd0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b0, 18'd0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 18'd260100};
    for (int i = 0; i < 8; i++) begin
      pair(tbl[i].a, tbl[i].b, tbl[i].last);
      if (tbl[i].last) begin
        check("table_acc", out_acc, tbl[i].exp);
        check("table_busy", {31'd0, busy}, 1);
        drain(i == 0 ? 5 : 0);
      end
    end

    @(negedge clk);
    in_a = 8'h80; in_b = 8'h80; in_last = 1; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    check("pre_reset_busy", {31'd0, busy}, 1);
    #2 reset_n = 0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_out_acc", out_acc, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    @(negedge clk); reset_n = 1;
    model = 0;
    pair(8'd2, 8'd3, 1'b1);
    check("post_reset_acc", out_acc, 6);
    drain(0);

    for (int d = 0; d < 25; d++) begin
      int len = $urandom_range(1, 6);
      for (int p = 0; p < len; p++) pair(8'($urandom), 8'($urandom), p == len - 1);
      check("rand_acc", out_acc, model);
      drain($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
